// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Byte-stream boot loader. It parses a host byte stream of
//            command / 16-bit length / payload segments and writes the
//            payload words into the instruction or data BRAM. On the run
//            command it releases the CPU program counter and hands the
//            data-BRAM write port to the CPU datapath.
// Ports    : clk, rst (async, active-low)
//            s_valid / s_data[7:0] / s_ready  - byte stream handshake
//            i_w_addr / i_w_dat / i_w_enb     - instruction BRAM write port
//            d_w_addr / d_w_dat / d_w_enb     - data BRAM write port
//            pc_stall, d_bram_init_done, err  - CPU control and status
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  pc_stall,
  output logic                  d_bram_init_done,
  output logic                  err
);

  localparam logic [7:0]  CMD_INSTR = 8'hA1;
  localparam logic [7:0]  CMD_DATA  = 8'hD1;
  localparam logic [7:0]  CMD_RUN   = 8'h5A;
  localparam logic [16:0] MAX_CNT   = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        accept;
  logic        tgt_data;     // 1 = data BRAM, 0 = instruction BRAM
  logic [7:0]  len_lo;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;

  logic [31:0] word_next;
  logic [16:0] len_full;
  logic [16:0] idx_inc;
  logic [ADDR_WIDTH-1:0] addr_now;

  // Bytes shift in from the top so the first byte ends up in bits 7:0.
  assign word_next = {s_data, asm_word[31:8]};
  assign len_full  = {1'b0, s_data, len_lo};
  assign idx_inc   = {1'b0, word_idx} + 17'd1;
  assign addr_now  = ADDR_WIDTH'({word_idx, 2'b00});
  assign accept    = s_valid & s_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx         = state;
    s_ready          = 1'b0;
    i_w_enb          = 1'b0;
    d_w_enb          = 1'b0;
    pc_stall         = 1'b1;
    d_bram_init_done = 1'b0;
    err              = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if ((s_data == CMD_INSTR) || (s_data == CMD_DATA)) begin
            state_nx = LEN_LO;
          end else if (s_data == CMD_RUN) begin
            state_nx = RUN;
          end else begin
            state_nx = ERR;
          end
        end
      end
      LEN_LO: begin
        s_ready = 1'b1;
        if (s_valid) state_nx = LEN_HI;
      end
      LEN_HI: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (len_full == 17'd0) begin
            state_nx = IDLE;
          end else if (len_full > MAX_CNT) begin
            state_nx = ERR;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        s_ready = 1'b1;
        if (s_valid && (byte_cnt == 2'd3)) state_nx = WRITE;
      end
      WRITE: begin
        i_w_enb  = ~tgt_data;
        d_w_enb  = tgt_data;
        state_nx = (idx_inc == {1'b0, count}) ? IDLE : DATA;
      end
      RUN: begin
        pc_stall         = 1'b0;
        d_bram_init_done = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: segment header, word assembly and BRAM port registers.
  // Address/data registers only change when a word completes, so they hold
  // their previous value whenever the enables are low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_data <= 1'b0;
      len_lo   <= 8'd0;
      count    <= 16'd0;
      word_idx <= 16'd0;
      byte_cnt <= 2'd0;
      asm_word <= 32'd0;
      i_w_addr <= '0;
      i_w_dat  <= '0;
      d_w_addr <= '0;
      d_w_dat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && ((s_data == CMD_INSTR) || (s_data == CMD_DATA))) begin
            tgt_data <= (s_data == CMD_DATA);
          end
        end
        LEN_LO: begin
          if (accept) len_lo <= s_data;
        end
        LEN_HI: begin
          if (accept) begin
            count    <= {s_data, len_lo};
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
          end
        end
        DATA: begin
          if (accept) begin
            asm_word <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            // Load the target port on the last byte so the word is
            // presented during the single WRITE cycle that follows.
            if (byte_cnt == 2'd3) begin
              if (tgt_data) begin
                d_w_addr <= addr_now;
                d_w_dat  <= DATA_WIDTH'(word_next);
              end else begin
                i_w_addr <= addr_now;
                i_w_dat  <= DATA_WIDTH'(word_next);
              end
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
